// File: rtl/seq_signed_divider.sv
`default_nettype none
// ============================================================================
// Module : seq_signed_divider
// Multi-cycle signed divider: 2W-bit dividend / W-bit divisor, radix-2
// restoring on magnitudes, then a sign-fixup cycle with saturation.
// Rev    : 1.0
// ============================================================================
module seq_signed_divider #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               ovf,
  output logic               dz
);

  localparam int CW = $clog2(2*WIDTH);
  localparam logic [CW-1:0]      c_LAST_ITER = CW'(2*WIDTH-1);
  localparam logic [2*WIDTH-1:0] c_POS_LIM   = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH-1:0] c_NEG_LIM   = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]   c_SAT_POS   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]   c_SAT_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sdvd_q, sdvd_d;
  logic               sdvs_q, sdvs_d;
  logic [2*WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [2*WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               ovf_q, ovf_d;
  logic               dz_q, dz_d;
  logic               out_valid_q, out_valid_d;

  logic [WIDTH:0]     w_shift;
  logic               w_borrow;
  logic               w_neg;
  logic               w_dvs_zero;
  logic               w_range_ovf;

  // Partial remainder stays below |divisor| <= 2^(WIDTH-1), so W bits hold it
  // between steps; only the shifted trial value needs the extra bit.
  assign w_shift     = {rem_q, dvd_q[2*WIDTH-1]};
  assign w_borrow    = w_shift < {1'b0, dvs_q};
  assign w_neg       = sdvd_q ^ sdvs_q;
  assign w_dvs_zero  = (dvs_q == '0);
  assign w_range_ovf = w_neg ? (quo_q > c_NEG_LIM) : (quo_q > c_POS_LIM);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sdvd_d      = sdvd_q;
    sdvs_d      = sdvs_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ovf_d       = ovf_q;
    dz_d        = dz_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sdvd_d  = dividend[2*WIDTH-1];
          sdvs_d  = divisor[WIDTH-1];
          dvd_d   = dividend[2*WIDTH-1] ? -dividend : dividend;
          dvs_d   = divisor[WIDTH-1] ? -divisor : divisor;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        dvd_d = {dvd_q[2*WIDTH-2:0], 1'b0};
        rem_d = w_borrow ? w_shift[WIDTH-1:0] : WIDTH'(w_shift - {1'b0, dvs_q});
        quo_d = {quo_q[2*WIDTH-2:0], ~w_borrow};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == c_LAST_ITER) begin
          state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        if (w_dvs_zero) begin
          dz_d        = 1'b1;
          ovf_d       = 1'b1;
          remainder_d = '0;
          quotient_d  = sdvd_q ? c_SAT_NEG : c_SAT_POS;
        end else begin
          dz_d        = 1'b0;
          ovf_d       = w_range_ovf;
          remainder_d = sdvd_q ? -rem_q : rem_q;
          if (w_range_ovf) begin
            quotient_d = w_neg ? c_SAT_NEG : c_SAT_POS;
          end else begin
            quotient_d = w_neg ? -quo_q[WIDTH-1:0] : quo_q[WIDTH-1:0];
          end
        end
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sdvd_q      <= 1'b0;
      sdvs_q      <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sdvd_q      <= sdvd_d;
      sdvs_q      <= sdvs_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ovf_q       <= ovf_d;
      dz_q        <= dz_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule
`default_nettype wire

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Multi-cycle signed integer divider, the inverse operation of the signed WIDTHxWIDTH multiplier.
- Takes a 2*WIDTH-bit signed dividend, for example a product from the multiplier datapath, and a WIDTH-bit signed divisor.
- Returns a WIDTH-bit truncated quotient and a WIDTH-bit remainder.
- Uses radix-2 restoring division on magnitudes, followed by a sign-fixup cycle.
- Valid/ready handshakes on both input and output.

Parameters:
- WIDTH, 8, operand width. Dividend is 2*WIDTH bits; divisor, quotient and remainder are WIDTH bits. Legal values are 4 to 32.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  dividend/divisor valid.
- in_ready  output  1  divider can accept operands.
- dividend  input  2*WIDTH  signed, two's complement.
- divisor  input  WIDTH  signed, two's complement.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  signed quotient, rounded toward zero, saturated on overflow.
- remainder  output  WIDTH  signed remainder; takes the sign of the dividend.
- ovf  output  1  quotient out of signed WIDTH range, or divide by zero.
- dz  output  1  divisor was zero.

Behaviour:
- Reset (rst high at an edge):
  - state goes to IDLE, the iteration counter clears, and any in-flight operation is discarded.
  - out_valid=0, quotient=0, remainder=0, ovf=0, dz=0, in_ready=1 after the edge.
  - rst takes priority over all other inputs.
- States IDLE, BUSY, FIXUP, DONE. in_ready = (state==IDLE), a registered state decode.
- IDLE:
  - On in_valid & in_ready, latch the operand signs, |dividend| (2*WIDTH bits, unsigned) and |divisor| (WIDTH bits, unsigned).
  - Clear the partial remainder (WIDTH+1 bits) and the quotient register (2*WIDTH bits), set count=0, go to BUSY.
- BUSY:
  - Each edge runs one restoring step: shift the next dividend MSB into the partial remainder, trial-subtract |divisor|, shift in quotient bit = NOT borrow, restore on borrow.
  - Runs exactly 2*WIDTH iterations, then goes to FIXUP. The iteration count is the same for every input, including divide by zero.
- FIXUP, one edge:
  - Negate the quotient if the signs differ; negate the remainder if the dividend is negative.
  - Range check: ovf=1 if the signed quotient is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]. A true quotient of exactly -2^(WIDTH-1) is legal.
  - On overflow, quotient saturates to 2^(WIDTH-1)-1 if the true sign is positive, or -2^(WIDTH-1) if negative. The remainder is still the exact remainder.
  - Divisor==0: dz=1, ovf=1, remainder=0. Quotient saturates by dividend sign: dividend>=0 gives max positive, dividend<0 gives max negative.
  - Registers the outputs, sets out_valid=1, goes to DONE.
- Latency: out_valid is high after the edge 2*WIDTH+1 cycles past the accepting edge (17 for WIDTH=8).
- DONE:
  - Outputs are held stable while out_valid & !out_ready.
  - On out_ready, the next edge clears out_valid and returns to IDLE. Throughput is one result per 2*WIDTH+3 cycles minimum.
- Operands do not need to be held after acceptance. in_valid is ignored outside IDLE.
- Magnitudes:
  - |-2^(2*WIDTH-1)| and |-2^(WIDTH-1)| must be represented without loss, as unsigned 2^(2*WIDTH-1) and 2^(WIDTH-1).
  - The trial subtract uses WIDTH+1 bits.

Test Plan (WIDTH=8):
- 100/7 -> q=14 (0x0E), r=2, ovf=0, dz=0; out_valid exactly 17 cycles after acceptance; in_ready low throughout.
- Sign matrix:
  - -100/7 -> q=0xF2 (-14), r=0xFE (-2).
  - 100/-7 -> q=0xF2, r=0x02.
  - -100/-7 -> q=0x0E, r=0xFE.
- Range edges:
  - 16384/-128 -> q=0x80, r=0, ovf=0.
  - -16384/-128 -> q=0x7F, ovf=1.
  - -32768/1 -> q=0x80, ovf=1.
  - 1000/7 -> q=0x7F, ovf=1, r=6.
- Divide by zero:
  - 1000/0 -> q=0x7F, r=0, ovf=1, dz=1, after 17 cycles.
  - -5/0 -> q=0x80.
  - 0/0 -> q=0x7F.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs and out_valid stable, in_ready=0. Raise out_ready -> out_valid=0 and in_ready=1 next edge; new operands accepted on the following edge.
- Reset mid-operation: assert rst at iteration 5 of 1000/7 -> next edge out_valid=0, in_ready=1, outputs 0. A fresh 100/7 then returns 14 r 2 with nominal latency.
